// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if -- bundle of the two requester ports and the unified memory
// port of mem_arbiter.
//
// Handshake: a requester raises reqN together with weN/addrN/wdN and keeps
// them stable until its doneN pulse. gntN marks ownership of the memory from
// the first BUSY cycle through the DONE cycle. doneN is a one-cycle
// completion pulse; for reads, rdata is valid on that pulse and holds until
// the next read completes. There is no separate ready: the grant/done pair
// closes each transaction.
//
// Signals:
//   req0/we0/addr0/wd0  port 0 (CPU) request, write enable, address, data
//   req1/we1/addr1/wd1  port 1 (loader) request, write enable, address, data
//   gnt0/gnt1           ownership of the memory
//   done0/done1         one-cycle completion pulse
//   rdata               captured read data
//   mem_addr/mem_wd     unified memory address and write data
//   mem_we              memory write strobe (one cycle per write)
//   mem_rd              combinational memory read data
//   busy                arbiter is not idle
// Modports: slave = arbiter side, master = requesters plus memory model.
interface mem_arbiter_if;
  logic        req0;
  logic        we0;
  logic [31:0] addr0;
  logic [31:0] wd0;
  logic        req1;
  logic        we1;
  logic [31:0] addr1;
  logic [31:0] wd1;
  logic        gnt0;
  logic        gnt1;
  logic        done0;
  logic        done1;
  logic [31:0] rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;
  logic        busy;

  modport slave (
    input  req0, we0, addr0, wd0,
    input  req1, we1, addr1, wd1,
    input  mem_rd,
    output gnt0, gnt1, done0, done1, rdata,
    output mem_addr, mem_wd, mem_we, busy
  );

  modport master (
    output req0, we0, addr0, wd0,
    output req1, we1, addr1, wd1,
    output mem_rd,
    input  gnt0, gnt1, done0, done1, rdata,
    input  mem_addr, mem_wd, mem_we, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter -- two-port round-robin arbiter in front of a single memory.
//
// A request seen in IDLE is granted, its command is latched, and the access
// runs for LAT BUSY cycles followed by one DONE cycle, then back to IDLE.
// The write strobe fires on the last BUSY cycle; read data is captured on
// that same cycle. When both ports request, the port not granted last wins.
//
// Parameters:
//   LAT        access length in BUSY cycles, 1..15
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   bus        mem_arbiter_if.slave (requesters and memory, see interface)
//   state_dbg  current FSM state (0 IDLE, 1 BUSY, 2 DONE)
module mem_arbiter #(
  parameter int unsigned LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  mem_arbiter_if.slave      bus,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAT_CNT = 4'(LAT);

  state_t      state;
  logic [3:0]  cnt;
  logic        owner;
  logic        last_owner;
  logic        lat_we;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wd_q;
  logic        mem_we_q;
  logic [31:0] rdata_q;
  logic        gnt0_q;
  logic        gnt1_q;
  logic        done0_q;
  logic        done1_q;
  logic        busy_q;

  // Arbitration decision for the current IDLE cycle.
  logic        pick;
  logic        pick_we;
  logic [31:0] pick_addr;
  logic [31:0] pick_wd;

  always_comb begin
    pick = 1'b0;
    if (bus.req0 && bus.req1) begin
      pick = ~last_owner;
    end else if (bus.req1) begin
      pick = 1'b1;
    end
    pick_we   = pick ? bus.we1   : bus.we0;
    pick_addr = pick ? bus.addr1 : bus.addr0;
    pick_wd   = pick ? bus.wd1   : bus.wd0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      owner      <= 1'b0;
      last_owner <= 1'b1;  // port 0 wins the first contention
      lat_we     <= 1'b0;
      mem_addr_q <= 32'd0;
      mem_wd_q   <= 32'd0;
      mem_we_q   <= 1'b0;
      rdata_q    <= 32'd0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            state      <= BUSY;
            cnt        <= LAT_CNT;
            owner      <= pick;
            last_owner <= pick;
            lat_we     <= pick_we;
            mem_addr_q <= pick_addr;
            mem_wd_q   <= pick_wd;
            // With a one-cycle access the first BUSY cycle is also the last.
            mem_we_q   <= pick_we && (LAT_CNT == 4'd1);
            gnt0_q     <= ~pick;
            gnt1_q     <= pick;
            busy_q     <= 1'b1;
          end
        end

        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state    <= DONE;
            mem_we_q <= 1'b0;
            if (!lat_we) begin
              rdata_q <= bus.mem_rd;
            end
            done0_q  <= ~owner;
            done1_q  <= owner;
          end else begin
            // Arm the strobe so it is high exactly while cnt == 1.
            mem_we_q <= lat_we && (cnt == 4'd2);
          end
        end

        DONE: begin
          state      <= IDLE;
          mem_addr_q <= 32'd0;
          mem_wd_q   <= 32'd0;
          mem_we_q   <= 1'b0;
          gnt0_q     <= 1'b0;
          gnt1_q     <= 1'b0;
          done0_q    <= 1'b0;
          done1_q    <= 1'b0;
          busy_q     <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt0     = gnt0_q;
  assign bus.gnt1     = gnt1_q;
  assign bus.done0    = done0_q;
  assign bus.done1    = done1_q;
  assign bus.rdata    = rdata_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_wd   = mem_wd_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.busy     = busy_q;
  assign state_dbg    = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- directed bench for mem_arbiter. Four instances with
// LAT = 1..4 share clock and reset, each with its own memory model.
module tb_mem_arbiter;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs and memory models ----------------
  mem_arbiter_if b1 ();
  mem_arbiter_if b2 ();
  mem_arbiter_if b3 ();
  mem_arbiter_if b4 ();

  logic [1:0] sd1, sd2, sd3, sd4;

  mem_arbiter #(.LAT(1)) a1 (.clk(clk), .rst(rst), .bus(b1), .state_dbg(sd1));
  mem_arbiter #(.LAT(2)) a2 (.clk(clk), .rst(rst), .bus(b2), .state_dbg(sd2));
  mem_arbiter #(.LAT(3)) a3 (.clk(clk), .rst(rst), .bus(b3), .state_dbg(sd3));
  mem_arbiter #(.LAT(4)) a4 (.clk(clk), .rst(rst), .bus(b4), .state_dbg(sd4));

  logic [31:0] m1 [256];
  logic [31:0] m2 [256];
  logic [31:0] m3 [256];
  logic [31:0] m4 [256];

  logic        ld_en;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data;

  assign b1.mem_rd = m1[b1.mem_addr[7:0]];
  assign b2.mem_rd = m2[b2.mem_addr[7:0]];
  assign b3.mem_rd = m3[b3.mem_addr[7:0]];
  assign b4.mem_rd = m4[b4.mem_addr[7:0]];

  always @(posedge clk) begin
    if (ld_en) m1[ld_addr] <= ld_data;
    else if (b1.mem_we) m1[b1.mem_addr[7:0]] <= b1.mem_wd;
  end
  always @(posedge clk) begin
    if (ld_en) m2[ld_addr] <= ld_data;
    else if (b2.mem_we) m2[b2.mem_addr[7:0]] <= b2.mem_wd;
  end
  always @(posedge clk) begin
    if (ld_en) m3[ld_addr] <= ld_data;
    else if (b3.mem_we) m3[b3.mem_addr[7:0]] <= b3.mem_wd;
  end
  always @(posedge clk) begin
    if (ld_en) m4[ld_addr] <= ld_data;
    else if (b4.mem_we) m4[b4.mem_addr[7:0]] <= b4.mem_wd;
  end

  // Event monitors: write strobes and done pulses per instance.
  int we_cnt1 = 0;
  int we_cnt4 = 0;
  int done_cnt4 = 0;
  always @(posedge clk) begin
    if (b1.mem_we) we_cnt1 <= we_cnt1 + 1;
    if (b4.mem_we) we_cnt4 <= we_cnt4 + 1;
    if (b4.done0 || b4.done1) done_cnt4 <= done_cnt4 + 1;
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input logic [7:0] a, input logic [31:0] d);
    ld_addr = a;
    ld_data = d;
    ld_en   = 1'b1;
    step();
    ld_en   = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b0;
    ld_en = 1'b0; ld_addr = 8'd0; ld_data = 32'd0;
    b1.req0 = 0; b1.we0 = 0; b1.addr0 = 0; b1.wd0 = 0; b1.req1 = 0; b1.we1 = 0; b1.addr1 = 0; b1.wd1 = 0;
    b2.req0 = 0; b2.we0 = 0; b2.addr0 = 0; b2.wd0 = 0; b2.req1 = 0; b2.we1 = 0; b2.addr1 = 0; b2.wd1 = 0;
    b3.req0 = 0; b3.we0 = 0; b3.addr0 = 0; b3.wd0 = 0; b3.req1 = 0; b3.we1 = 0; b3.addr1 = 0; b3.wd1 = 0;
    b4.req0 = 0; b4.we0 = 0; b4.addr0 = 0; b4.wd0 = 0; b4.req1 = 0; b4.we1 = 0; b4.addr1 = 0; b4.wd1 = 0;

    // Memory preload (all four models) while reset is held.
    ld(8'h10, 32'hDEADBEEF);
    ld(8'h20, 32'h0);
    ld(8'h40, 32'h0);
    ld(8'h44, 32'h0);
    ld(8'h50, 32'hCAFEF00D);
    ld(8'h60, 32'h00001234);
    ld(8'h64, 32'h0);

    // Reset state.
    chk("rst_state", 32'(sd1), 32'd0);
    chk("rst_busy", 32'(b1.busy), 32'd0);
    chk("rst_gnt", {30'd0, b1.gnt1, b1.gnt0}, 32'd0);
    chk("rst_done", {30'd0, b1.done1, b1.done0}, 32'd0);
    chk("rst_rdata", b1.rdata, 32'd0);
    chk("rst_mem_addr", b1.mem_addr, 32'd0);
    chk("rst_mem_we", 32'(b1.mem_we), 32'd0);

    rst = 1'b1;
    step();

    // LAT=1 port 0 read of 0x10.
    b1.req0 = 1; b1.we0 = 0; b1.addr0 = 32'h10;
    step();
    chk("r37_gnt0", 32'(b1.gnt0), 32'd1);
    chk("r37_gnt1", 32'(b1.gnt1), 32'd0);
    chk("r37_busy", 32'(b1.busy), 32'd1);
    chk("r37_mem_addr", b1.mem_addr, 32'h10);
    step();
    chk("r37_done0", 32'(b1.done0), 32'd1);
    chk("r37_gnt0_done", 32'(b1.gnt0), 32'd1);
    chk("r37_rdata", b1.rdata, 32'hDEADBEEF);
    b1.req0 = 0;
    step();
    chk("r37_idle_state", 32'(sd1), 32'd0);
    chk("r37_idle_gnt", {30'd0, b1.gnt1, b1.gnt0}, 32'd0);
    chk("r37_idle_done", 32'(b1.done0), 32'd0);
    chk("r37_idle_mem_addr", b1.mem_addr, 32'd0);
    chk("r37_no_we", 32'(we_cnt1), 32'd0);

    // LAT=3 port 1 write 0x5A5A5A5A to 0x20, then read back via port 0.
    b3.req1 = 1; b3.we1 = 1; b3.addr1 = 32'h20; b3.wd1 = 32'h5A5A5A5A;
    step();
    chk("r38_gnt1", 32'(b3.gnt1), 32'd1);
    chk("r38_we_t1", 32'(b3.mem_we), 32'd0);
    step();
    chk("r38_we_t2", 32'(b3.mem_we), 32'd0);
    step();
    chk("r38_we_t3", 32'(b3.mem_we), 32'd1);
    chk("r38_addr_t3", b3.mem_addr, 32'h20);
    chk("r38_wd_t3", b3.mem_wd, 32'h5A5A5A5A);
    step();
    chk("r38_done1", 32'(b3.done1), 32'd1);
    chk("r38_we_t4", 32'(b3.mem_we), 32'd0);
    b3.req1 = 0; b3.we1 = 0;
    step();
    chk("r38_mem", m3[8'h20], 32'h5A5A5A5A);
    b3.req0 = 1; b3.we0 = 0; b3.addr0 = 32'h20;
    step();
    chk("r38_rb_gnt0", 32'(b3.gnt0), 32'd1);
    step(); step(); step();
    chk("r38_rb_done0", 32'(b3.done0), 32'd1);
    chk("r38_rb_rdata", b3.rdata, 32'h5A5A5A5A);
    b3.req0 = 0;
    step();

    // Round-robin under constant contention after reset (LAT=2).
    rst = 1'b0;
    step();
    rst = 1'b1;
    b2.req0 = 1; b2.addr0 = 32'h10; b2.req1 = 1; b2.addr1 = 32'h10;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("r39_gnt0_%0d", k), 32'(b2.gnt0), 32'(k % 2 == 0));
      chk($sformatf("r39_gnt1_%0d", k), 32'(b2.gnt1), 32'(k % 2 == 1));
      step(); step();
      chk($sformatf("r39_done_%0d", k), {30'd0, b2.done1, b2.done0},
          (k % 2 == 0) ? 32'd1 : 32'd2);
      step();
      chk($sformatf("r39_idle_%0d", k), 32'(b2.busy), 32'd0);
    end
    b2.req0 = 0; b2.req1 = 0;
    step();

    // LAT=2 port 0 write with inputs changed and req dropped after grant.
    b2.req0 = 1; b2.we0 = 1; b2.addr0 = 32'h40; b2.wd0 = 32'h11112222;
    step();
    chk("r40_gnt0", 32'(b2.gnt0), 32'd1);
    b2.req0 = 0; b2.addr0 = 32'h44; b2.wd0 = 32'h99999999;
    step();
    chk("r40_we", 32'(b2.mem_we), 32'd1);
    chk("r40_addr", b2.mem_addr, 32'h40);
    chk("r40_wd", b2.mem_wd, 32'h11112222);
    step();
    chk("r40_done0", 32'(b2.done0), 32'd1);
    step();
    chk("r40_mem40", m2[8'h40], 32'h11112222);
    chk("r40_mem44", m2[8'h44], 32'h0);
    chk("r40_idle", 32'(sd2), 32'd0);
    b2.we0 = 0;

    // LAT=4 port 1 write aborted by reset at T+2.
    b4.req1 = 1; b4.we1 = 1; b4.addr1 = 32'h50; b4.wd1 = 32'h0BADBEEF;
    step();
    chk("r41_gnt1", 32'(b4.gnt1), 32'd1);
    step();
    rst = 1'b0;
    #1;
    chk("r41_async_gnt", {30'd0, b4.gnt1, b4.gnt0}, 32'd0);
    chk("r41_async_busy", 32'(b4.busy), 32'd0);
    chk("r41_async_addr", b4.mem_addr, 32'd0);
    chk("r41_async_state", 32'(sd4), 32'd0);
    b4.req1 = 0; b4.we1 = 0;
    step();
    rst = 1'b1;
    for (int k = 0; k < 6; k++) step();
    chk("r41_no_we", 32'(we_cnt4), 32'd0);
    chk("r41_no_done", 32'(done_cnt4), 32'd0);
    chk("r41_mem", m4[8'h50], 32'hCAFEF00D);

    // LAT=1 port 1 read then port 0 write: rdata holds.
    b1.req1 = 1; b1.we1 = 0; b1.addr1 = 32'h60;
    step();
    chk("r42_gnt1", 32'(b1.gnt1), 32'd1);
    step();
    chk("r42_done1", 32'(b1.done1), 32'd1);
    chk("r42_rdata", b1.rdata, 32'h00001234);
    b1.req1 = 0;
    step();
    b1.req0 = 1; b1.we0 = 1; b1.addr0 = 32'h64; b1.wd0 = 32'hFFFF0000;
    step();
    chk("r42_w_we", 32'(b1.mem_we), 32'd1);
    chk("r42_w_rdata_busy", b1.rdata, 32'h00001234);
    step();
    chk("r42_w_done0", 32'(b1.done0), 32'd1);
    chk("r42_w_rdata_done", b1.rdata, 32'h00001234);
    b1.req0 = 0; b1.we0 = 0;
    step();
    chk("r42_mem", m1[8'h64], 32'hFFFF0000);
    chk("r42_we_count", 32'(we_cnt1), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter LAT, default 1, SHALL set the memory access length in BUSY cycles; legal range 1..15.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-low reset.
REQ-005 req0, we0  in  1 each  port 0 (CPU) request and write enable.
REQ-006 addr0, wd0  in  32 each  port 0 address and write data.
REQ-007 req1, we1  in  1 each  port 1 (loader) request and write enable.
REQ-008 addr1, wd1  in  32 each  port 1 address and write data.
REQ-009 gnt0, gnt1  out  1 each  port owns the memory, BUSY and DONE states.
REQ-010 done0, done1  out  1 each  one-cycle completion pulse.
REQ-011 rdata  out  32  read data, valid on a done pulse and held until the next done pulse.
REQ-012 mem_addr, mem_wd  out  32 each  unified memory address and write data.
REQ-013 mem_we  out  1  memory write strobe.
REQ-014 mem_rd  in  32  memory combinational read data.
REQ-015 busy  out  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-017 In IDLE with req0|req1 high, the block SHALL pick an owner, latch its we/addr/wd, load cnt=LAT and enter BUSY on the next edge.
REQ-018 Arbitration SHALL be round-robin when both requests are high: grant the port not granted last (last_owner register).
REQ-019 When only one port requests, that port SHALL be granted regardless of last_owner.
REQ-020 last_owner SHALL update on every grant.
REQ-021 In BUSY, mem_addr/mem_wd SHALL be driven from the latched values, and cnt SHALL decrement each cycle.
REQ-022 The transition to DONE SHALL occur on the edge where cnt==1.
REQ-023 mem_we SHALL be high for exactly one cycle, the final BUSY cycle (cnt==1), and only for a latched write.
REQ-024 On the final BUSY cycle the block SHALL capture mem_rd into rdata for reads; writes SHALL leave rdata unchanged.
REQ-025 In DONE, done<owner> SHALL pulse high for one cycle, and the next state SHALL be IDLE unconditionally.
REQ-026 Timing: req sampled in IDLE at cycle T -> BUSY T+1..T+LAT -> done at T+LAT+1 -> IDLE at T+LAT+2.
REQ-027 The owner's gnt SHALL be high from T+1 through T+LAT+1; the other gnt SHALL stay low.
REQ-028 A requester SHALL hold req and its inputs stable until done; inputs that change after the grant SHALL be ignored (latched copy used).
REQ-029 A req deasserted mid-transaction SHALL NOT abort it: the access completes and done still pulses.
REQ-030 A req still high in the IDLE cycle after DONE SHALL be treated as a new transaction.
REQ-031 Requests arriving during BUSY/DONE SHALL wait; no request is lost while it is held.
REQ-032 In IDLE, mem_addr, mem_wd and mem_we SHALL be 0, and gnt0/gnt1/done0/done1 SHALL be 0.
REQ-033 Back-to-back alternating grants SHALL leave exactly one IDLE cycle between transactions.

Reset
REQ-034 Asserting rst low SHALL immediately force: state IDLE, cnt 0, last_owner=1 (port 0 wins the first contention), rdata 0, all outputs 0.
REQ-035 A reset mid-BUSY SHALL abort the transaction: no mem_we and no done pulse.
REQ-036 After rst is released, the first operation SHALL be arbitration in IDLE on the next rising edge.

Verification
REQ-037 LAT=1; port 0 read, addr0=0x10, memory holds 0xDEADBEEF -> gnt0 at T+1, done0 at T+2 with rdata=0xDEADBEEF, mem_we never high.
REQ-038 LAT=3; port 1 write, addr1=0x20, wd1=0x5A5A5A5A -> mem_we high only at T+3 with mem_addr=0x20; done1 at T+4; readback via port 0 returns 0x5A5A5A5A.
REQ-039 After reset, req0 and req1 both held high -> grant order 0,1,0,1; each done is followed by one IDLE cycle before the next grant.
REQ-040 LAT=2; port 0 write granted, then addr0/wd0 changed and req0 dropped at T+1 -> write uses the original values, and done0 still pulses at T+3.
REQ-041 LAT=4; rst pulsed low at T+2 during a port 1 write -> outputs 0 immediately, no mem_we, no done1, memory location unchanged.
REQ-042 Port 1 read completes with rdata=0x1234, followed by a port 0 write -> rdata stays 0x1234 through the write's done0.
